keypad_scan_ctrl: RTL
=====================

# keypad_scan_ctrl

Keypad scan controller placed between the 4x4 matrix keypad pins and the CPU's I/O port. It drives the column strobes at a programmable dwell rate, synchronises and debounces the row returns, and converts each new debounced key press into a 4-bit hex code. Each code is queued in a small FIFO that the CPU drains through a valid/ack handshake, so no key is lost or repeated.

## Interface
- SCAN_DIV, default 1000: clock cycles each column stays driven (dwell); legal range ≥ 4.
- DEBOUNCE, default 4: consecutive identical scan frames required before a key state becomes stable; legal range ≥ 1.
- FIFO_DEPTH, default 4: key-code queue entries; power of two.
- Clock  input  1  single system clock, rising edge.
- Reset_N  input  1  asynchronous, active-low reset.
- Row  input  4  row returns, active low; bit0 is the top row.
- Col  output  4  column strobe, one-hot active low; bit0 is the left column.
- KeypadData  output  8  FIFO head; {4'h0, code}.
- KeyValid  output  1  FIFO not empty.
- KeyAck  input  1  pops the head on a rising edge when KeyValid=1.
- KeyHeld  output  1  high while the debounced state is a key.
- Overflow  output  1  sticky; set when a code is dropped because the FIFO is full.
- ClearOvf  input  1  clears Overflow.

## Operation
- Key map as (Col low bit, Row low bit) -> code:
  - col0: rows 0..3 -> 1,4,7,0
  - col1: rows 0..3 -> 2,5,8,F
  - col2: rows 0..3 -> 3,6,9,E
  - col3: rows 0..3 -> A,B,C,D
- Row passes through a 2-flop synchroniser before any use.
- Scan sequence:
  - Dwell counter runs 0..SCAN_DIV-1.
  - The synchronised Row is sampled at count SCAN_DIV-1.
  - Col then rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - One frame is 4 dwells (4*SCAN_DIV cycles).
- Frame candidate, evaluated at frame end after the column-3 sample:
  - NONE: zero low row bits across all four columns.
  - KEY(c): exactly one low bit in the frame.
  - MULTI: two or more low bits. MULTI is discarded; the debounce counter and stable state are unchanged.
- Debounce:
  - If candidate == last candidate, the match counter increments, saturating at DEBOUNCE. Otherwise the counter is set to 1 and the last candidate is updated.
  - When the counter reaches DEBOUNCE and the candidate differs from the stable state, the stable state takes the candidate value.
- State machine transitions:
  - IDLE (stable NONE) -> PRESSED(c) on stable KEY(c): push c.
  - PRESSED(c) -> PRESSED(d), d≠c: push d.
  - PRESSED -> IDLE on stable NONE: no push.
  - A held key never repeats.
- FIFO:
  - KeypadData shows the head combinationally from registered storage.
  - Pop when KeyAck & KeyValid. KeyAck while empty is ignored.
- Push into a full FIFO with no simultaneous pop: code is dropped and Overflow is set.
- Push and pop in the same cycle:
  - Full FIFO: both are performed, occupancy unchanged, no overflow.
  - Empty FIFO: pop is ignored, push lands.
- ClearOvf and a new overflow in the same cycle: Overflow stays 1 (set wins).
- KeyHeld = (state == PRESSED).

## Timing
- Reset values: Col=4'b1110, KeypadData=8'h00, KeyValid=0, KeyHeld=0, Overflow=0. Reset also clears dwell counter, synchroniser, candidate, match counter and FIFO pointers.
- Reset asserted mid-frame or mid-debounce: all of the above return to reset values immediately; any queued codes are discarded.
- Push happens on the clock edge after the frame-end evaluation that reaches DEBOUNCE. KeyValid rises on the following edge.
- Press-to-KeyValid worst case: (DEBOUNCE+1)*4*SCAN_DIV + 4 cycles, counted from the first synchronised sample.
- Pop: KeyAck sampled high at edge N -> new head (or KeyValid=0) visible after edge N. Back-to-back pops, one per cycle, are legal.
- Col changes exactly once every SCAN_DIV cycles; no idle gaps between frames.

## Test plan
All scenarios run with SCAN_DIV=4 and DEBOUNCE=2.
- Reset -> Col=1110 and rotates every 4 cycles. KeyValid=0, KeypadData=00, Overflow=0.
- Hold the key at col2/row1 for 3 frames, then release -> exactly one push of 8'h06; KeyHeld high, then low after 2 NONE frames. KeyAck -> KeyValid=0.
- Key at col1/row3 bounces (present, absent, present on alternate frames) for 4 frames, then stays steady for 2 frames -> single code 8'h0F, pushed only after the steady frames.
- Press col0/row0 and col3/row3 together -> MULTI, no push. Release col3 -> after 2 frames one push of 8'h01.
- Five distinct press/release keys (1, 2, 3, A, 0) with no KeyAck -> FIFO holds 01, 02, 03, 0A. Overflow=1. Reads return those four in order. ClearOvf -> Overflow=0.
- FIFO full and a push coincides with KeyAck -> occupancy stays 4, new code is at the tail, Overflow stays 0. Reset_N pulsed low mid-frame -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: column strobe generation, row synchronisation,
// frame-based debounce, press detection and a small key-code FIFO for the CPU.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       Clock,
  input  logic       Reset_N,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [7:0] KeypadData,
  output logic       KeyValid,
  input  logic       KeyAck,
  output logic       KeyHeld,
  output logic       Overflow,
  input  logic       ClearOvf
);

  localparam int unsigned CntW   = $clog2(SCAN_DIV);
  localparam int unsigned MatchW = $clog2(DEBOUNCE + 1);
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0]   CntLast  = CntW'(SCAN_DIV - 1);
  localparam logic [MatchW-1:0] MatchMax = MatchW'(DEBOUNCE);
  localparam logic [AddrW:0]    DepthP   = (AddrW + 1)'(FIFO_DEPTH);

  typedef enum logic {StIdle, StPressed} state_e;

  // Candidate / stable encoding: {is_key, code}; NONE is 5'b0.
  logic [3:0]        row_s1_q, row_s2_q;
  logic [CntW-1:0]   cnt_q;
  logic [1:0]        col_q;
  logic [1:0]        frame_lows_q, frame_lows_d;
  logic [3:0]        frame_code_q, frame_code_d;
  logic [4:0]        last_q, last_d;
  logic [4:0]        stable_q, stable_d;
  logic [MatchW-1:0] match_q, match_d;
  state_e            state_q, state_d;
  logic [3:0]        key_q, key_d;
  logic              push;

  logic [AddrW:0]    wr_q, rd_q;
  logic [3:0]        mem_q [FIFO_DEPTH];
  logic              ovf_q;

  logic              sample, frame_end, multi;
  logic [3:0]        row_low;
  logic [2:0]        n_low;
  logic [1:0]        row_idx;
  logic [3:0]        lows_sum;
  logic [4:0]        cand;

  logic              empty, full, pop, do_push, drop;

  function automatic logic [3:0] key_code(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    case ({col, row})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = 4'h0;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'hF;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hE;
      4'b11_00: code = 4'hA;
      4'b11_01: code = 4'hB;
      4'b11_10: code = 4'hC;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  assign sample    = (cnt_q == CntLast);
  assign frame_end = sample && (col_q == 2'd3);
  assign row_low   = ~row_s2_q;
  assign n_low     = {2'b0, row_low[0]} + {2'b0, row_low[1]} + {2'b0, row_low[2]} +
                     {2'b0, row_low[3]};

  // Two-flop synchroniser on the row returns; idle level is all-high.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= Row;
      row_s2_q <= row_s1_q;
    end
  end

  // Dwell counter and column rotation; the column advances on the sample cycle.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      cnt_q <= '0;
      col_q <= 2'd0;
    end else if (sample) begin
      cnt_q <= '0;
      col_q <= col_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign Col = ~(4'b0001 << col_q);

  // Row index of the lowest active row; only meaningful when exactly one is low.
  always_comb begin
    row_idx = 2'd0;
    if (row_low[0])      row_idx = 2'd0;
    else if (row_low[1]) row_idx = 2'd1;
    else if (row_low[2]) row_idx = 2'd2;
    else if (row_low[3]) row_idx = 2'd3;
  end

  // Accumulate low-bit count (saturating at 2) and the single-key code over a frame.
  always_comb begin
    logic [1:0] base_lows;
    logic [3:0] base_code;
    base_lows    = (col_q == 2'd0) ? 2'd0 : frame_lows_q;
    base_code    = (col_q == 2'd0) ? 4'h0 : frame_code_q;
    lows_sum     = {2'b0, base_lows} + {1'b0, n_low};
    frame_lows_d = (lows_sum >= 4'd2) ? 2'd2 : lows_sum[1:0];
    frame_code_d = (n_low == 3'd1) ? key_code(col_q, row_idx) : base_code;
    multi        = (frame_lows_d == 2'd2);
    cand         = (frame_lows_d == 2'd1) ? {1'b1, frame_code_d} : 5'b0;
  end

  // Frame accumulator registers, loaded on every column sample.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      frame_lows_q <= 2'd0;
      frame_code_q <= 4'h0;
    end else if (sample) begin
      frame_lows_q <= frame_lows_d;
      frame_code_q <= frame_code_d;
    end
  end

  // Debounce: count matching frame candidates, MULTI frames leave everything alone.
  always_comb begin
    last_d   = last_q;
    match_d  = match_q;
    stable_d = stable_q;
    if (frame_end && !multi) begin
      if (cand == last_q) begin
        if (match_q != MatchMax) match_d = match_q + MatchW'(1);
      end else begin
        match_d = MatchW'(1);
        last_d  = cand;
      end
      if (match_d == MatchMax && cand != stable_q) stable_d = cand;
    end
  end

  // Debounce state registers.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      last_q   <= 5'b0;
      match_q  <= '0;
      stable_q <= 5'b0;
    end else begin
      last_q   <= last_d;
      match_q  <= match_d;
      stable_q <= stable_d;
    end
  end

  // Press FSM next state: push once per new stable key, never on release or hold.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (stable_q[4]) begin
          push    = 1'b1;
          state_d = StPressed;
          key_d   = stable_q[3:0];
        end
      end
      StPressed: begin
        if (!stable_q[4]) begin
          state_d = StIdle;
        end else if (stable_q[3:0] != key_q) begin
          push  = 1'b1;
          key_d = stable_q[3:0];
        end
      end
    endcase
  end

  // Press FSM state register.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state_q <= StIdle;
      key_q   <= 4'h0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
    end
  end

  assign KeyHeld = (state_q == StPressed);

  assign empty   = (wr_q == rd_q);
  assign full    = ((wr_q - rd_q) == DepthP);
  assign pop     = KeyAck && !empty;
  assign do_push = push && (!full || pop);
  assign drop    = push && full && !pop;

  // FIFO pointers and sticky overflow; a new overflow beats ClearOvf.
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      wr_q  <= '0;
      rd_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + (AddrW + 1)'(1);
      if (pop)     rd_q <= rd_q + (AddrW + 1)'(1);
      if (drop)          ovf_q <= 1'b1;
      else if (ClearOvf) ovf_q <= 1'b0;
    end
  end

  // FIFO storage; contents are only visible through the pointers so need no reset.
  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_q[AddrW-1:0]] <= key_d;
  end

  assign KeyValid   = !empty;
  assign KeypadData = empty ? 8'h00 : {4'h0, mem_q[rd_q[AddrW-1:0]]};
  assign Overflow   = ovf_q;

endmodule
